// File: rtl/dmem_arb_pkg.sv
// Shared types and size codes for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HALF  = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] BYTEU = 3'b100;
  localparam logic [2:0] HALFU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == BYTE) || (f3 == HALF) || (f3 == WORD) ||
           (f3 == BYTEU) || (f3 == HALFU);
  endfunction

  // Unsigned codes only make sense for loads.
  function automatic logic f3_writable(input logic [2:0] f3);
    return (f3 == BYTE) || (f3 == HALF) || (f3 == WORD);
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of a latched memory command.
module dmem_access_check
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  err
);

  logic out_of_range, bad_f3, bad_wr, mis_half, mis_word;

  assign out_of_range = |addr[DATA_WIDTH-1:ADDR_WIDTH];
  assign bad_f3       = !f3_legal(funct3);
  assign bad_wr       = we && !f3_writable(funct3);
  assign mis_half     = ((funct3 == HALF) || (funct3 == HALFU)) && addr[0];
  assign mis_word     = (funct3 == WORD) && (addr[1:0] != 2'b00);

  assign err = out_of_range | bad_f3 | bad_wr | mis_half | mis_word;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single data memory.
// Each access takes IDLE -> ACCESS -> RESP; the ack pulses in RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic                  mem_we,
  output logic [2:0]            mem_funct3,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  cmd_port_q, cmd_port_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [2:0]            cmd_f3_q, cmd_f3_d;
  logic [DATA_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  grant, acc_err;

  // On a tie the port that did not win last time gets the grant.
  assign grant = (p0_req && p1_req) ? !last_q : p1_req;

  dmem_access_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_check (
    .we     (cmd_we_q),
    .funct3 (cmd_f3_q),
    .addr   (cmd_addr_q),
    .err    (acc_err)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_f3_d    = cmd_f3_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d     = ACCESS;
          last_d      = grant;
          cmd_port_d  = grant;
          cmd_we_d    = grant ? p1_we     : p0_we;
          cmd_f3_d    = grant ? p1_funct3 : p0_funct3;
          cmd_addr_d  = grant ? p1_addr   : p0_addr;
          cmd_wdata_d = grant ? p1_wdata  : p0_wdata;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = acc_err ? '0 : mem_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_f3_q    <= 3'b000;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_f3_q    <= cmd_f3_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_we     = (state_q == ACCESS) && cmd_we_q && !acc_err;
  assign mem_funct3 = cmd_f3_q;
  assign mem_addr   = cmd_addr_q;
  assign mem_wdata  = cmd_wdata_q;

  assign p0_ack   = (state_q == RESP) && !cmd_port_q;
  assign p1_ack   = (state_q == RESP) &&  cmd_port_q;
  assign p0_err   = p0_ack && acc_err;
  assign p1_err   = p1_ack && acc_err;
  assign p0_rdata = rdata_q;
  assign p1_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-lane memory model.
module tb_dmem_arbiter;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_funct3, p1_funct3;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_word;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] o,
                                      input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      F_B:     return {{24{b[7]}}, b};
      F_H:     return {{16{h[15]}}, h};
      F_BU:    return {24'b0, b};
      F_HU:    return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] o, input logic [2:0] f3);
    logic [31:0] r;
    r = w;
    case (f3)
      F_B:     r[{o, 3'b000} +: 8] = wd[7:0];
      F_H:     if (o[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign mem_word  = mem[mem_addr[11:2]];
  assign mem_rdata = ext(mem_word, mem_addr[1:0], mem_funct3);

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_addr[11:2]] <= merge(mem_word, mem_wdata, mem_addr[1:0], mem_funct3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input logic p, input logic req, input logic we,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      p0_req = req; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = wd;
    end
  endtask

  task automatic preload(input logic [9:0] i, input logic [31:0] v);
    @(negedge clk); pl_en = 1'b1; pl_idx = i; pl_val = v;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, 32'({p0_ack, p1_ack, p0_err, p1_err, mem_we}), 32'd0);
    chk({nm, "_rd"}, p0_rdata | p1_rdata, 32'd0);
    chk({nm, "_mem"}, mem_addr | mem_wdata | 32'(mem_funct3), 32'd0);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
  } vec_t;

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    logic oth, wes, gerr;
    logic [31:0] grd;
    lat = 0; oth = 0; wes = 0; gerr = 0; grd = '0;
    @(negedge clk);
    set_port(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we) wes = 1'b1;
      if (v.port ? p0_ack : p1_ack) oth = 1'b1;
      if ((v.port ? p1_ack : p0_ack) && lat == 0) begin
        lat  = c;
        gerr = v.port ? p1_err : p0_err;
        grd  = v.port ? p1_rdata : p0_rdata;
        set_port(v.port, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      end
    end
    set_port(v.port, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    chk($sformatf("v%0d_latency", n), lat, 32'd2);
    chk($sformatf("v%0d_err", n), 32'(gerr), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", n), grd, v.exp_rdata);
    chk($sformatf("v%0d_other_ack", n), 32'(oth), 32'd0);
    chk($sformatf("v%0d_mem_we", n), 32'(wes), 32'(v.we && !v.exp_err));
    chk($sformatf("v%0d_mem", n), mem[v.addr[11:2]], v.exp_mem);
  endtask

  // Records ack cycles (bit c set = ack seen c negedges after start); each port
  // drops its request on its max-th ack. p1 is raised at cycle p1_start if nonzero.
  task automatic run_log(input string nm, input int ncyc, input int max0, input int max1,
                         input int p1_start, input logic [31:0] rd0, input logic [31:0] rd1,
                         output logic [31:0] l0, output logic [31:0] l1);
    int n0, n1;
    n0 = 0; n1 = 0; l0 = '0; l1 = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (p0_ack) begin
        l0[c] = 1'b1; n0++;
        chk($sformatf("%s_p0_rdata%0d", nm, n0), p0_rdata, rd0);
        if (n0 >= max0) p0_req = 1'b0;
      end
      if (p1_ack) begin
        l1[c] = 1'b1; n1++;
        chk($sformatf("%s_p1_rdata%0d", nm, n1), p1_rdata, rd1);
        if (n1 >= max1) p1_req = 1'b0;
      end
      if (c == p1_start) p1_req = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  vec_t vt[13];
  logic [31:0] l0, l1;
  int acks;

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    set_port(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    //          port we  f3     addr          wdata         err   rdata         mem after
    vt[0]  = '{1'b0, 1'b0, F_W,   32'h0001_0000, 32'h0,         1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 1'b1, F_W,   32'h0001_0002, 32'hAAAAAAAA,  1'b1, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{1'b0, 1'b0, F_HU,  32'h0002_0000, 32'h0,         1'b1, 32'h0,        32'hDEADBEEF};
    vt[3]  = '{1'b1, 1'b1, F_W,   32'h0000_0100, 32'hCAFEF00D,  1'b0, 32'h11111111, 32'hCAFEF00D};
    vt[4]  = '{1'b0, 1'b0, F_B,   32'h0001_0001, 32'h0,         1'b0, 32'hFFFFFFBE, 32'hDEADBEEF};
    vt[5]  = '{1'b1, 1'b0, F_H,   32'h0001_0002, 32'h0,         1'b0, 32'hFFFFDEAD, 32'hDEADBEEF};
    vt[6]  = '{1'b0, 1'b1, F_BU,  32'h0000_0100, 32'h12345678,  1'b1, 32'h0,        32'hCAFEF00D};
    vt[7]  = '{1'b1, 1'b0, F_BAD, 32'h0001_0000, 32'h0,         1'b1, 32'h0,        32'hDEADBEEF};
    vt[8]  = '{1'b0, 1'b0, F_H,   32'h0001_0003, 32'h0,         1'b1, 32'h0,        32'hDEADBEEF};
    vt[9]  = '{1'b0, 1'b0, F_HU,  32'h0000_0102, 32'h0,         1'b0, 32'h0000CAFE, 32'hCAFEF00D};
    vt[10] = '{1'b1, 1'b1, F_B,   32'h0000_0103, 32'h000000AB,  1'b0, 32'hFFFFFFCA, 32'hABFEF00D};
    vt[11] = '{1'b0, 1'b0, F_W,   32'h0000_0002, 32'h0,         1'b1, 32'h0,        32'hDEADBEEF};
    vt[12] = '{1'b0, 1'b1, F_HU,  32'h0000_0100, 32'h5555,      1'b1, 32'h0,        32'hABFEF00D};

    repeat (2) @(negedge clk);
    chk_quiet("reset_held");
    preload(10'd0, 32'hDEADBEEF);
    preload(10'd64, 32'h11111111);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset_released");

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // Tie from reset: p0 first, p1 three cycles later.
    do_reset();
    preload(10'd64, 32'h0);
    preload(10'd128, 32'h0);
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, F_W, 32'h100, 32'hA1A1A1A1);
    set_port(1'b1, 1'b1, 1'b1, F_W, 32'h200, 32'hB2B2B2B2);
    run_log("tie", 8, 1, 1, 0, 32'h0, 32'h0, l0, l1);
    chk("tie_p0_acks", l0, 32'h4);
    chk("tie_p1_acks", l1, 32'h20);
    chk("tie_mem_p0", mem[64], 32'hA1A1A1A1);
    chk("tie_mem_p1", mem[128], 32'hB2B2B2B2);

    // Reset in the middle of a write: nothing commits, nothing acks.
    do_reset();
    preload(10'd1, 32'h55555555);
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, F_W, 32'h0001_0004, 32'h12345678);
    @(posedge clk); #1;
    chk("rstacc_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1; #1;
    chk_quiet("rstacc_during");
    acks = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
      if (c == 1) p0_req = 1'b0;
      if (c == 2) rst = 1'b0;
    end
    chk("rstacc_no_ack", acks, 32'd0);
    chk("rstacc_mem", mem[1], 32'h55555555);
    chk_quiet("rstacc_after");

    // p0 holds req for three reads: acks every third cycle.
    do_reset();
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, F_W, 32'h0001_0000, 32'h0);
    run_log("b2b", 11, 3, 9, 0, 32'hDEADBEEF, 32'h0, l0, l1);
    chk("b2b_p0_acks", l0, 32'h124);
    chk("b2b_p1_acks", l1, 32'h0);

    // p1 joins after the first p0 ack; grants alternate from then on.
    do_reset();
    @(negedge clk);
    set_port(1'b1, 1'b0, 1'b0, F_W, 32'h0001_0004, 32'h0);
    set_port(1'b0, 1'b1, 1'b0, F_W, 32'h0001_0000, 32'h0);
    run_log("alt", 17, 3, 2, 2, 32'hDEADBEEF, 32'h55555555, l0, l1);
    chk("alt_p0_acks", l0, 32'h4104);
    chk("alt_p1_acks", l1, 32'h820);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data/address bus width.
REQ-002 Parameter ADDR_WIDTH, default 17, byte-address width of the data memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pN_req  input  1  port N (N=0 CPU, N=1 DMA) access request; held with its command until pN_ack.
REQ-006 pN_we  input  1  port N write (1) / read (0).
REQ-007 pN_funct3  input  3  port N size/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 pN_addr  input  DATA_WIDTH  port N byte address.
REQ-009 pN_wdata  input  DATA_WIDTH  port N write data.
REQ-010 pN_ack  output  1  one-cycle completion pulse for port N.
REQ-011 pN_rdata  output  DATA_WIDTH  read data, valid while pN_ack high.
REQ-012 pN_err  output  1  access rejected, valid while pN_ack high.
REQ-013 mem_we  output  1  data-memory write enable.
REQ-014 mem_funct3  output  3  data-memory size control.
REQ-015 mem_addr  output  DATA_WIDTH  data-memory address.
REQ-016 mem_wdata  output  DATA_WIDTH  data-memory write data.
REQ-017 mem_rdata  input  DATA_WIDTH  data-memory combinational read data.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any pN_req high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 In IDLE, winner latched into command registers (port id, we, funct3, addr, wdata) on the IDLE->ACCESS edge.
REQ-020 Arbitration: single requester wins; both requesting -> port not granted last wins; last-grant pointer updates on each grant.
REQ-021 mem_* outputs driven from command registers; mem_we = 1 only in ACCESS with latched we=1 and no error; 0 in IDLE/RESP.
REQ-022 Read data sampled from mem_rdata on the ACCESS->RESP edge into a shared rdata register.
REQ-023 In RESP, pN_ack=1 for granted port only, exactly one cycle; other port ack=0; pN_rdata shows rdata register for both ports.
REQ-024 Latency: req seen at edge T0 -> memory access cycle T0..T1 -> ack cycle T1..T2; max throughput one access per 3 cycles.
REQ-025 req still high in the IDLE cycle after RESP is a new request.
REQ-026 Error conditions: addr bits [DATA_WIDTH-1:ADDR_WIDTH] nonzero; half access with addr[0]=1; word access with addr[1:0]!=0; write with funct3 not in {000,001,010}; any funct3 not in REQ-007 list.
REQ-027 Error access: no memory write, rdata register loads 0, pN_err=1 with pN_ack; FSM timing unchanged.
REQ-028 Non-error access: pN_err=0; rdata = mem_rdata unmodified (extension done by memory).
REQ-029 Requests arriving during ACCESS/RESP are not lost; served after return to IDLE.

Reset
REQ-030 rst forces state IDLE, last-grant pointer = port 1 (port 0 wins first tie), command and rdata registers 0.
REQ-031 During/after reset: all pN_ack=0, pN_err=0, pN_rdata=0, mem_we=0, mem_funct3=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset asserted during ACCESS drops mem_we immediately; write not committed, no ack issued.

Structure
REQ-033 Package dmem_arb_pkg holds state enum (IDLE, ACCESS, RESP) and funct3 constants (BYTE, HALF, WORD, BYTEU, HALFU).
REQ-034 Sub-module dmem_access_check: combinational legality check (we, funct3, addr -> err) per REQ-026.

Verification
REQ-035 p0 read word addr 0x10000, mem holds 0xDEADBEEF -> p0_ack 2 cycles after req edge, p0_rdata=0xDEADBEEF, p0_err=0.
REQ-036 p0 and p1 both write word from reset -> p0 served first, p1 next; pointer alternates on repeated ties.
REQ-037 p1 write word addr 0x10002 -> p1_ack, p1_err=1, mem_we never high, memory unchanged.
REQ-038 p0 read half-unsigned addr 0x20000 (out of range) -> p0_err=1, p0_rdata=0.
REQ-039 rst pulsed during ACCESS of p0 write 0x12345678 to 0x10004 -> no ack, memory at 0x10004 unchanged, outputs at reset values.
REQ-040 p0 holds req for 3 back-to-back reads -> three acks spaced 3 cycles apart, p1 request interleaved when asserted.
